// File: rtl/music_pkg.sv
// Constants and types shared by the note ROMs, the sequencer and the tone generator.
package music_pkg;

  localparam int unsigned NOTE_W        = 8;
  localparam int unsigned STEP_W        = 8;
  localparam int unsigned SONG0_LEN_DEF = 84;
  localparam int unsigned SONG1_LEN_DEF = 243;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_PAUSED,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic play;
    logic pause;
    logic stop;
  } seq_cmd_t;

  // stop beats pause beats play; only the winner survives
  function automatic seq_cmd_t resolve_cmd(
    input logic play,
    input logic pause,
    input logic stop
  );
    seq_cmd_t c;
    c.stop  = stop;
    c.pause = pause & ~stop;
    c.play  = play & ~pause & ~stop;
    return c;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step countdown for the sequencer: load, enable, zero flag and gap compare.
module step_timer #(
  parameter int unsigned W   = 24,
  parameter int unsigned GAP = 1
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o,
  output logic         gap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign gap_o  = (32'(cnt_q) < GAP);

endmodule

// File: rtl/song_sequencer.sv
// Note-ROM playback controller: play/pause/stop, song select, looping.
// Define ARTIC_GAP_EN to silence the last GAP_CYCLES of every step.
module song_sequencer
  import music_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 16777216,
  parameter int unsigned SONG0_LEN   = SONG0_LEN_DEF,
  parameter int unsigned SONG1_LEN   = SONG1_LEN_DEF,
  parameter int unsigned GAP_CYCLES  = 1048576
) (
  input  logic              CLK100MHZ,
  input  logic              rst_n,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              song_sel,
  input  logic              loop_en,
  output logic [STEP_W-1:0] rom_addr,
  output logic              rom_song,
  input  logic [NOTE_W-1:0] rom_note,
  output logic [NOTE_W-1:0] note_out,
  output logic              playing,
  output logic              song_done
);

  localparam int unsigned TW = $clog2(TICK_CYCLES);

  localparam logic [TW-1:0] TickLoad =
    TW'(TICK_CYCLES - 3);

  localparam logic [STEP_W-1:0] Last0 =
    STEP_W'(SONG0_LEN - 1);
  localparam logic [STEP_W-1:0] Last1 =
    STEP_W'(SONG1_LEN - 1);

`ifdef ARTIC_GAP_EN
  localparam logic GapEn = 1'b1;
`else
  localparam logic GapEn = 1'b0;
`endif

  seq_state_t state_q, state_d;

  logic [STEP_W-1:0] step_q, step_d;
  logic [NOTE_W-1:0] held_q, held_d;
  logic              song_q, song_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;

  logic     tmr_load;
  logic     tmr_en;
  logic     tick_zero;
  logic     tick_gap;
  logic     last;
  seq_cmd_t cmd;

  assign cmd  = resolve_cmd(play, pause, stop);
  assign last = (step_q == (song_q ? Last1 : Last0));

  step_timer #(
    .W   (TW),
    .GAP (GAP_CYCLES)
  ) u_timer (
    .clk_i      (CLK100MHZ),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (TickLoad),
    .en_i       (tmr_en),
    .zero_o     (tick_zero),
    .gap_o      (tick_gap)
  );

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (cmd.play) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d = (pend_q || cmd.pause) ?
                  S_PAUSED : S_PLAY;
      end
      S_PLAY: begin
        if (cmd.pause) begin
          state_d = S_PAUSED;
        end else if (tick_zero) begin
          state_d = (last && !loop_en) ?
                    S_DONE : S_FETCH;
        end
      end
      S_PAUSED: begin
        if (cmd.play) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
    if (cmd.stop) state_d = S_IDLE;
  end

  always_comb begin
    step_d   = step_q;
    song_d   = song_q;
    held_d   = held_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (cmd.play) begin
          step_d = '0;
          song_d = song_sel;
          held_d = NOTE_REST;
        end
      end
      S_FETCH: begin
        if (cmd.pause) pend_d = 1'b1;
      end
      S_LOAD: begin
        held_d   = rom_note;
        tmr_load = 1'b1;
        pend_d   = 1'b0;
      end
      S_PLAY: begin
        if (!cmd.pause) begin
          if (!tick_zero) begin
            tmr_en = 1'b1;
          end else if (last) begin
            done_d = 1'b1;
            if (loop_en) step_d = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      default: ;
    endcase
    if (cmd.stop) begin
      step_d   = '0;
      held_d   = NOTE_REST;
      pend_d   = 1'b0;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      song_q <= 1'b0;
      held_q <= NOTE_REST;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      song_q <= song_d;
      held_q <= held_d;
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end

  // FETCH/LOAD keep the previous note sounding across the step boundary
  always_comb begin
    playing  = 1'b0;
    note_out = NOTE_REST;
    unique case (state_q)
      S_FETCH, S_LOAD: begin
        playing  = 1'b1;
        note_out = held_q;
      end
      S_PLAY: begin
        playing  = 1'b1;
        note_out = (GapEn && tick_gap) ?
                   NOTE_REST : held_q;
      end
      default: ;
    endcase
  end

  assign rom_addr  = step_q;
  assign rom_song  = song_q;
  assign song_done = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: vector table, directed corners, random vs model.
module tb_song_sequencer;

  localparam int TICK   = 8;
  localparam int S0_LEN = 4;
  localparam int S1_LEN = 243;
  localparam int GAP    = 2;
`ifdef ARTIC_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       play, pause, stop;
  logic       song_sel, loop_en;
  logic [7:0] rom_addr;
  logic       rom_song;
  logic [7:0] rom_q;
  logic [7:0] note_out;
  logic       playing;
  logic       song_done;

  int checks = 0;
  int errors = 0;

  song_sequencer #(
    .TICK_CYCLES (TICK),
    .SONG0_LEN   (S0_LEN),
    .SONG1_LEN   (S1_LEN),
    .GAP_CYCLES  (GAP)
  ) dut (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .play      (play),
    .pause     (pause),
    .stop      (stop),
    .song_sel  (song_sel),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_song  (rom_song),
    .rom_note  (rom_q),
    .note_out  (note_out),
    .playing   (playing),
    .song_done (song_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(
    input bit song, input logic [7:0] a);
    logic [7:0] s0 [4];
    s0 = '{8'd29, 8'd0, 8'd34, 8'd41};
    if (song) return a + 8'd50;
    return (a < 4) ? s0[a[1:0]] : 8'd0;
  endfunction

  always @(posedge clk) rom_q <= rom_val(rom_song, rom_addr);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // reference model: a song position = (step, phase within the step's TICK cycles)
  bit   m_active, m_paused, m_pend, m_song, m_done;
  int   m_phase, m_step;
  logic [7:0] m_cur;
  bit   c_rst, c_pl, c_pa, c_st, c_sel, c_lp;

  always @(posedge clk) begin
    c_rst <= rst_n;
    c_pl  <= play;
    c_pa  <= pause;
    c_st  <= stop;
    c_sel <= song_sel;
    c_lp  <= loop_en;
  end

  task automatic m_reset();
    m_active = 0; m_paused = 0; m_pend = 0;
    m_song = 0; m_done = 0; m_phase = 0;
    m_step = 0; m_cur = 0;
  endtask

  task automatic m_step_t(input bit pl, pa, st, sel, lp);
    bit do_pa, do_pl;
    int len;
    do_pa = pa && !st;
    do_pl = pl && !pa && !st;
    len = m_song ? S1_LEN : S0_LEN;
    m_done = 0;
    if (st) begin
      m_active = 0; m_paused = 0; m_pend = 0;
      m_step = 0; m_cur = 0;
    end else if (!m_active) begin
      if (do_pl) begin
        m_active = 1; m_phase = 0; m_step = 0;
        m_song = sel; m_cur = 0;
      end
    end else if (m_paused) begin
      if (do_pl) m_paused = 0;
    end else if (m_phase == 0) begin
      if (do_pa) m_pend = 1;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_cur = rom_val(m_song, 8'(m_step));
      m_phase = 2;
      if (do_pa || m_pend) m_paused = 1;
      m_pend = 0;
    end else if (do_pa) begin
      m_paused = 1;
    end else if (m_phase < TICK - 1) begin
      m_phase++;
    end else if (m_step < len - 1) begin
      m_step++;
      m_phase = 0;
    end else begin
      m_done = 1;
      if (lp) begin
        m_step = 0; m_phase = 0;
      end else begin
        m_active = 0;
      end
    end
  endtask

  function automatic logic [7:0] m_note();
    if (!m_active || m_paused) return 8'd0;
    if (m_phase < 2) return m_cur;
    if (GAP_ON && (TICK - 1 - m_phase) < GAP)
      return 8'd0;
    return m_cur;
  endfunction

  always @(negedge clk) begin
    if (!rst_n || !c_rst) m_reset();
    else m_step_t(c_pl, c_pa, c_st, c_sel, c_lp);
    chk("model.note", note_out, m_note());
    chk("model.playing", playing,
        m_active && !m_paused);
    chk("model.addr", rom_addr, m_step);
    chk("model.song", rom_song, m_song);
    chk("model.done", song_done, m_done);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit pl, pa, st);
    play = pl; pause = pa; stop = st;
    @(posedge clk);
    #1;
    play = 0; pause = 0; stop = 0;
  endtask

  typedef struct {
    bit         pl, pa, st, sel, lp;
    int         n;
    logic [7:0] note;
    bit         plg;
    logic [7:0] addr;
    bit         done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input bit pl, pa, st, sel, lp, input int n,
    input int note, input bit plg,
    input int addr, input bit done);
    vec_t v;
    v.pl = pl; v.pa = pa; v.st = st;
    v.sel = sel; v.lp = lp; v.n = n;
    v.note = 8'(note); v.plg = plg;
    v.addr = 8'(addr); v.done = done;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    rst_n = 0; play = 0; pause = 0; stop = 0;
    song_sel = 0; loop_en = 0;
    cycles(3);
    chk("rst.note", note_out, 0);
    chk("rst.playing", playing, 0);
    chk("rst.addr", rom_addr, 0);
    chk("rst.song", rom_song, 0);
    chk("rst.done", song_done, 0);
    rst_n = 1;
    cycles(3);
    chk("idle.playing", playing, 0);

    // pl pa st sel lp n  note plg addr done
    tbl.push_back(mk(1,0,0,0,0, 1,  0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 2, 29,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 6, 29,1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 2,  0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 8, 34,1,2,0));
    tbl.push_back(mk(0,0,0,0,0, 8, 41,1,3,0));
    tbl.push_back(mk(0,0,0,0,0, 6,  0,0,3,1));
    tbl.push_back(mk(0,0,0,0,0, 1,  0,0,3,0));
    tbl.push_back(mk(1,0,0,0,1, 1,  0,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,32, 41,1,0,1));
    tbl.push_back(mk(0,0,0,0,1, 1, 41,1,0,0));
    tbl.push_back(mk(0,0,0,0,1, 1, 29,1,0,0));
    tbl.push_back(mk(1,1,1,0,1, 1,  0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 3, 29,1,0,0));
    tbl.push_back(mk(1,1,0,0,0, 1,  0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 29,1,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,  0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,  0,1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,  0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,  0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 5,  0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 29,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 6, 29,1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 1,  0,0,0,0));

    foreach (tbl[i]) begin
      song_sel = tbl[i].sel;
      loop_en  = tbl[i].lp;
      pulse(tbl[i].pl, tbl[i].pa, tbl[i].st);
      if (tbl[i].n > 1) cycles(tbl[i].n - 1);
      chk($sformatf("vec%0d.note", i), note_out, tbl[i].note);
      chk($sformatf("vec%0d.playing", i), playing, tbl[i].plg);
      chk($sformatf("vec%0d.addr", i), rom_addr, tbl[i].addr);
      chk($sformatf("vec%0d.done", i), song_done, tbl[i].done);
    end

    // long pause in the middle of note 34 at tick 3
    song_sel = 0; loop_en = 0;
    pulse(1, 0, 0);
    cycles(20);
    chk("pause.pre", note_out, 34);
    pulse(0, 1, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (note_out !== 0 || rom_addr !== 2 ||
          playing !== 0) bad++;
      cycles(1);
    end
    chk("pause.hold", bad, 0);
    pulse(1, 0, 0);
    chk("resume.note", note_out, 34);
    cycles(3);
    chk("resume.tick0", note_out, 34);
    cycles(1);
    chk("resume.addr", rom_addr, 3);
    cycles(2);
    chk("resume.next", note_out, 41);
    pulse(0, 0, 1);

    // async reset in the middle of PLAY
    pulse(1, 0, 0);
    cycles(3);
    chk("prerst.note", note_out, 29);
    #2 rst_n = 0;
    #1;
    chk("midrst.note", note_out, 0);
    chk("midrst.playing", playing, 0);
    chk("midrst.addr", rom_addr, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    cycles(4);
    chk("postrst.playing", playing, 0);

    // song 1 runs its full length
    song_sel = 1;
    pulse(1, 0, 0);
    chk("s1.song", rom_song, 1);
    song_sel = 0;
    n = 0;
    while (song_done !== 1'b1 && n < 3000) begin
      cycles(1);
      n++;
    end
    chk("s1.len", n, S1_LEN * TICK);
    chk("s1.addr", rom_addr, S1_LEN - 1);
    cycles(1);
    pulse(0, 0, 1);

`ifdef ARTIC_GAP_EN
    pulse(1, 0, 0);
    cycles(5);
    chk("gap.on", note_out, 29);
    cycles(1);
    chk("gap.t1", note_out, 0);
    cycles(1);
    chk("gap.t0", note_out, 0);
    cycles(1);
    chk("gap.period", rom_addr, 1);
    pulse(0, 0, 1);
`endif

    for (int i = 0; i < 4000; i++) begin
      song_sel = 1'($urandom_range(0, 1));
      loop_en  = 1'($urandom_range(0, 1));
      play  = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      cycles(1);
    end
    play = 0; pause = 0; stop = 0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
